scratchpad_arbiter: RTL and testbench

Round-robin arbiter that shares one scratchpad memory port among up to four requesters in the processing element: DDMA, MMIO, and optional debug or instruction-fetch agents. Each requester issues single-beat reads or writes with a lock/last burst protocol. The block grants one beat per cycle, routes registered read data back to the issuing requester, and bounds burst length so that no requester starves.

---
 rtl/scratchpad_arbiter.sv | 118 +++++++++++
 tb/tb_scratchpad_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scratchpad_arbiter.sv
// scratchpad_arbiter: round-robin arbiter sharing one scratchpad port among requesters with burst locking
module scratchpad_arbiter #(
    parameter int MEMORY_BUS_WIDTH = 32,
    parameter int ADDR_WIDTH       = 16,
    parameter int NUM_REQ          = 2,
    parameter int MAX_BURST        = 16
) (
    input  logic                                      clock,
    input  logic                                      reset,
    input  logic [NUM_REQ-1:0]                        req_i,
    input  logic [NUM_REQ-1:0]                        we_i,
    input  logic [NUM_REQ-1:0]                        last_i,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]        addr_i,
    input  logic [NUM_REQ-1:0][MEMORY_BUS_WIDTH-1:0]  wdata_i,
    output logic [NUM_REQ-1:0]                        gnt_o,
    output logic [NUM_REQ-1:0]                        rvalid_o,
    output logic [MEMORY_BUS_WIDTH-1:0]               rdata_o,
    output logic                                      mem_en_o,
    output logic                                      mem_we_o,
    output logic [ADDR_WIDTH-1:0]                     mem_addr_o,
    output logic [MEMORY_BUS_WIDTH-1:0]               mem_wdata_o,
    input  logic [MEMORY_BUS_WIDTH-1:0]               mem_rdata_i
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(MAX_BURST) + 1;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t               r_state, w_state_nx;
    logic [PW-1:0]        r_rr_ptr, w_rr_ptr_nx;
    logic [PW-1:0]        r_owner, w_owner_nx;
    logic [CW-1:0]        r_beat_cnt, w_beat_cnt_nx;
    logic                 r_rd_pend;
    logic [PW-1:0]        r_rd_tag;
    logic [2*NUM_REQ-1:0] w_rot;
    logic [PW:0]          w_sum;
    logic [PW-1:0]        w_off, w_win, w_sel, w_sel_inc;
    logic                 w_any, w_go, w_rel;

    // rotate requests so the scan starts at rr_ptr, then map the first hit back to an index
    always_comb begin
        w_rot = {req_i, req_i} >> r_rr_ptr;
        w_off = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--)
            if (w_rot[i]) w_off = PW'(i);
        w_any = |req_i;
        w_sum = {1'b0, r_rr_ptr} + {1'b0, w_off};
        w_win = (w_sum >= (PW+1)'(NUM_REQ)) ? PW'(w_sum - (PW+1)'(NUM_REQ)) : w_sum[PW-1:0];
    end

    // while locked only the owner is eligible; grants are suppressed during reset
    always_comb begin
        w_sel     = (r_state == IDLE) ? w_win : r_owner;
        w_go      = reset & ((r_state == IDLE) ? w_any : req_i[w_sel]);
        w_rel     = last_i[w_sel] | (r_beat_cnt + 1'b1 == CW'(MAX_BURST));
        w_sel_inc = (w_sel == PW'(NUM_REQ - 1)) ? '0 : w_sel + 1'b1;
    end

    // lock bookkeeping: a granted beat either releases (advance pointer) or extends the lock
    always_comb begin
        w_state_nx    = r_state;
        w_rr_ptr_nx   = r_rr_ptr;
        w_owner_nx    = r_owner;
        w_beat_cnt_nx = r_beat_cnt;
        if (w_go) begin
            if (w_rel) begin
                w_state_nx    = IDLE;
                w_rr_ptr_nx   = w_sel_inc;
                w_beat_cnt_nx = '0;
            end else begin
                w_state_nx    = LOCKED;
                w_owner_nx    = w_sel;
                w_beat_cnt_nx = r_beat_cnt + 1'b1;
            end
        end
    end

    // memory port and grant vector driven from the selected requester, zero when idle
    always_comb begin
        gnt_o       = w_go ? NUM_REQ'(1) << w_sel : '0;
        mem_en_o    = w_go;
        mem_we_o    = w_go & we_i[w_sel];
        mem_addr_o  = w_go ? addr_i[w_sel] : '0;
        mem_wdata_o = w_go ? wdata_i[w_sel] : '0;
    end

    // read data returns one cycle after the grant to the tagged requester
    always_comb begin
        rvalid_o = r_rd_pend ? NUM_REQ'(1) << r_rd_tag : '0;
        rdata_o  = r_rd_pend ? mem_rdata_i : '0;
    end

    // arbitration state registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_rr_ptr   <= '0;
            r_owner    <= '0;
            r_beat_cnt <= '0;
        end else begin
            r_state    <= w_state_nx;
            r_rr_ptr   <= w_rr_ptr_nx;
            r_owner    <= w_owner_nx;
            r_beat_cnt <= w_beat_cnt_nx;
        end
    end

    // pending read tracking, dropped at once by reset
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rd_pend <= 1'b0;
            r_rd_tag  <= '0;
        end else begin
            r_rd_pend <= w_go & ~we_i[w_sel];
            r_rd_tag  <= w_sel;
        end
    end
endmodule

// File: tb/tb_scratchpad_arbiter.sv
// tb_scratchpad_arbiter: directed and randomized checks of scratchpad_arbiter against a behavioural model
module tb_scratchpad_arbiter;
    localparam int N  = 3;
    localparam int MB = 4;
    localparam int DW = 32;
    localparam int AW = 16;
    localparam int PW = 2;

    logic                 clock = 1'b0;
    logic                 reset = 1'b0;
    logic [N-1:0]         req = '0, we = '0, last = '0;
    logic [N-1:0][AW-1:0] addr = '0;
    logic [N-1:0][DW-1:0] wdata = '0;
    logic [N-1:0]         gnt_o, rvalid_o;
    logic [DW-1:0]        rdata_o, mem_wdata_o, mem_rdata_i;
    logic                 mem_en_o, mem_we_o;
    logic [AW-1:0]        mem_addr_o;

    int n_vec = 0;
    int n_err = 0;
    int rst_hold = 0;

    always #5 clock = ~clock;

    scratchpad_arbiter #(
        .MEMORY_BUS_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(N), .MAX_BURST(MB)
    ) dut (
        .clock(clock), .reset(reset), .req_i(req), .we_i(we), .last_i(last),
        .addr_i(addr), .wdata_i(wdata), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
        .rdata_o(rdata_o), .mem_en_o(mem_en_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
    );

    function automatic logic [31:0] init_val(input logic [15:0] a);
        return (a == 16'h0010) ? 32'hDEADBEEF : {~a, a};
    endfunction

    // scratchpad memory: one-cycle read latency
    logic [31:0]  env_mem [256];
    logic [255:0] env_ok = '0;
    always @(posedge clock) begin
        if (mem_en_o) begin
            if (mem_we_o) begin
                env_mem[mem_addr_o[7:0]] <= mem_wdata_o;
                env_ok[mem_addr_o[7:0]]  <= 1'b1;
            end else begin
                mem_rdata_i <= env_ok[mem_addr_o[7:0]] ? env_mem[mem_addr_o[7:0]] : init_val(mem_addr_o);
            end
        end
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // behavioural model state
    bit          m_locked;
    int          m_owner, m_ptr, m_beats, m_tag;
    bit          m_pend;
    logic [31:0] m_rdat;
    logic [N-1:0] m_gnt;
    logic [31:0] mm [256];
    bit          mm_ok [256];

    task automatic model_step();
        int g;
        logic [N-1:0] eg;
        logic [7:0] a8;
        if (!reset) begin
            check("rst_gnt", 64'(gnt_o), 64'h0);
            check("rst_rvalid", 64'(rvalid_o), 64'h0);
            check("rst_rdata", 64'(rdata_o), 64'h0);
            check("rst_en", 64'(mem_en_o), 64'h0);
            check("rst_we", 64'(mem_we_o), 64'h0);
            check("rst_addr", 64'(mem_addr_o), 64'h0);
            check("rst_wdata", 64'(mem_wdata_o), 64'h0);
            m_locked = 0; m_ptr = 0; m_beats = 0; m_pend = 0; m_gnt = '0;
        end else begin
            g = -1;
            if (m_locked) begin
                if (req[PW'(m_owner)]) g = m_owner;
            end else begin
                for (int k = 0; k < N; k++)
                    if (g < 0 && req[PW'((m_ptr + k) % N)]) g = (m_ptr + k) % N;
            end
            eg = (g < 0) ? '0 : N'(1) << g;
            check("gnt", 64'(gnt_o), 64'(eg));
            check("mem_en", 64'(mem_en_o), 64'(g >= 0));
            check("mem_we", 64'(mem_we_o), 64'((g >= 0) ? we[PW'(g)] : 1'b0));
            check("mem_addr", 64'(mem_addr_o), 64'((g >= 0) ? addr[PW'(g)] : 16'h0));
            check("mem_wdata", 64'(mem_wdata_o), 64'((g >= 0) ? wdata[PW'(g)] : 32'h0));
            check("rvalid", 64'(rvalid_o), 64'(m_pend ? N'(1) << m_tag : N'(0)));
            if (m_pend) check("rdata", 64'(rdata_o), 64'(m_rdat));
            m_pend = 0;
            m_gnt = eg;
            if (g >= 0) begin
                a8 = addr[PW'(g)][7:0];
                if (we[PW'(g)]) begin
                    mm[a8] = wdata[PW'(g)];
                    mm_ok[a8] = 1;
                end else begin
                    m_pend = 1;
                    m_tag = g;
                    m_rdat = mm_ok[a8] ? mm[a8] : init_val(addr[PW'(g)]);
                end
                m_beats++;
                if (last[PW'(g)] || m_beats == MB) begin
                    m_locked = 0; m_ptr = (g + 1) % N; m_beats = 0;
                end else begin
                    m_locked = 1; m_owner = g;
                end
            end
        end
    endtask

    initial begin
        m_locked = 0; m_owner = 0; m_ptr = 0; m_beats = 0; m_tag = 0; m_pend = 0;
        m_rdat = '0; m_gnt = '0;
        for (int i = 0; i < 256; i++) mm_ok[i] = 0;
        forever begin
            @(negedge clock);
            model_step();
        end
    end

    task automatic nxt();
        @(posedge clock);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clock);
    endtask

    initial begin
        // reset held with random inputs
        for (int c = 0; c < 3; c++) begin
            req = N'($urandom); we = N'($urandom); last = N'($urandom);
            for (int k = 0; k < N; k++) begin
                addr[PW'(k)] = AW'($urandom);
                wdata[PW'(k)] = $urandom;
            end
            at_neg();
            check("t_rst_gnt", 64'(gnt_o), 64'h0);
            check("t_rst_rvalid", 64'(rvalid_o), 64'h0);
            check("t_rst_en", 64'(mem_en_o), 64'h0);
            check("t_rst_addr", 64'(mem_addr_o), 64'h0);
            check("t_rst_rdata", 64'(rdata_o), 64'h0);
            nxt();
        end
        reset = 1; req = 3'b010; we = '0; last = 3'b111; addr[1] = 16'h0020;
        at_neg();
        check("t_first_gnt", 64'(gnt_o), 64'h2);
        nxt();
        req = '0;
        at_neg();
        check("t_first_rvalid", 64'(rvalid_o), 64'h2);
        nxt();
        // single read of 0x0010
        req = 3'b001; addr[0] = 16'h0010;
        at_neg();
        check("t_read_gnt", 64'(gnt_o), 64'h1);
        check("t_read_addr", 64'(mem_addr_o), 64'h10);
        nxt();
        req = '0;
        at_neg();
        check("t_read_rvalid", 64'(rvalid_o), 64'h1);
        check("t_read_rdata", 64'(rdata_o), 64'hDEADBEEF);
        nxt();
        // single beat from requester 2 brings the pointer back to 0
        req = 3'b100; addr[2] = 16'h0050;
        at_neg();
        check("t_r2_gnt", 64'(gnt_o), 64'h4);
        nxt();
        // round-robin fairness between 0 and 1
        req = 3'b011; addr[0] = 16'h0001; addr[1] = 16'h0021;
        for (int c = 0; c < 8; c++) begin
            at_neg();
            check("t_rr", 64'(gnt_o), (c % 2) ? 64'h2 : 64'h1);
            nxt();
        end
        // 4-beat write burst from 0 while 1 waits
        req = 3'b011; we = 3'b001; addr[1] = 16'h0030; last[1] = 1'b1;
        for (int b = 0; b < 4; b++) begin
            addr[0] = 16'h0040 + 16'(b); wdata[0] = 32'h11110000 + 32'(b); last[0] = (b == 3);
            at_neg();
            check("t_lock", 64'(gnt_o), 64'h1);
            nxt();
        end
        req[0] = 1'b0;
        at_neg();
        check("t_handover", 64'(gnt_o), 64'h2);
        nxt();
        // read back the burst
        req = '0; we = '0;
        for (int b = 0; b < 5; b++) begin
            req[0] = (b < 4);
            addr[0] = 16'h0040 + 16'(b % 4); last[0] = (b == 3);
            at_neg();
            if (b > 0) begin
                check("t_rb_rvalid", 64'(rvalid_o), 64'h1);
                check("t_rb_rdata", 64'(rdata_o), 64'h11110000 + 64'(b - 1));
            end
            nxt();
        end
        // cap and stall
        req = 3'b001; we = 3'b001; last = 3'b010; addr[0] = 16'h0080; wdata[0] = $urandom;
        at_neg();
        check("t_cap_b1", 64'(gnt_o), 64'h1);
        nxt();
        req = 3'b011; we = 3'b001; addr[1] = 16'h0031; addr[0] = 16'h0081; wdata[0] = $urandom;
        at_neg();
        check("t_cap_b2", 64'(gnt_o), 64'h1);
        nxt();
        req[0] = 1'b0;
        for (int c = 0; c < 2; c++) begin
            at_neg();
            check("t_stall", 64'(gnt_o), 64'h0);
            nxt();
        end
        req[0] = 1'b1;
        for (int b = 2; b < 4; b++) begin
            addr[0] = 16'h0080 + 16'(b); wdata[0] = $urandom;
            at_neg();
            check("t_cap_b34", 64'(gnt_o), 64'h1);
            nxt();
        end
        addr[0] = 16'h0084; wdata[0] = $urandom;
        at_neg();
        check("t_cap_handover", 64'(gnt_o), 64'h2);
        nxt();
        req[1] = 1'b0;
        for (int b = 4; b < 10; b++) begin
            addr[0] = 16'h0080 + 16'(b); wdata[0] = $urandom;
            at_neg();
            check("t_cap_rest", 64'(gnt_o), 64'h1);
            nxt();
        end
        // reset during beat 3 of a read burst
        req = 3'b001; we = '0; last = '0;
        for (int b = 0; b < 2; b++) begin
            addr[0] = 16'h0040 + 16'(b);
            at_neg();
            check("t_rb3_gnt", 64'(gnt_o), 64'h1);
            nxt();
        end
        addr[0] = 16'h0042;
        reset = 0;
        at_neg();
        check("t_mid_rvalid", 64'(rvalid_o), 64'h0);
        check("t_mid_gnt", 64'(gnt_o), 64'h0);
        nxt();
        at_neg();
        nxt();
        reset = 1; req = 3'b010; last = 3'b010; addr[1] = 16'h0033;
        at_neg();
        check("t_post_rst_gnt", 64'(gnt_o), 64'h2);
        check("t_post_rst_rvalid", 64'(rvalid_o), 64'h0);
        nxt();
        req = '0;
        // randomized traffic honouring the hold-until-grant rule
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (rst_hold > 0) begin
                rst_hold--;
                if (rst_hold == 0) reset = 1;
            end else if ($urandom_range(0, 249) == 0) begin
                reset = 0;
                rst_hold = $urandom_range(1, 3);
            end
            for (int k = 0; k < N; k++) begin
                if (!req[PW'(k)] || m_gnt[PW'(k)]) begin
                    if ($urandom_range(0, 3) != 0) begin
                        req[PW'(k)]   = 1'b1;
                        we[PW'(k)]    = 1'($urandom_range(0, 1));
                        last[PW'(k)]  = ($urandom_range(0, 2) == 0);
                        addr[PW'(k)]  = AW'($urandom_range(0, 31));
                        wdata[PW'(k)] = $urandom;
                    end else begin
                        req[PW'(k)] = 1'b0;
                    end
                end
            end
            at_neg();
            nxt();
        end
        reset = 1; req = '0;
        at_neg();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
